// File: rtl/mem_bus.sv
// mem_bus: memory-side slave for the CPU bus. RAM below 0x8000, MMIO page
// (UART TX FIFO, status, free-running cycle counter) at 0x8000 and above.
// Reads are registered with a fixed one-cycle latency. rdata holds its value
// until the next accepted read.
//
// UART states:
//   state   | meaning
//   S_IDLE  | line high, pops the next byte when the FIFO is non-empty
//   S_START | start bit (low) for CLK_DIV cycles
//   S_DATA  | 8 data bits LSB first, CLK_DIV cycles each
//   S_STOP  | stop bit (high) for CLK_DIV cycles
module mem_bus #(
    parameter int DEPTH      = 4096,
    parameter     INIT_FILE  = "",
    parameter int CLK_DIV    = 104,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ren,
    input  logic        wen,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    output logic [31:0] rdata,
    output logic        rd_valid,
    output logic        uart_tx
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   ram_rd_q;
    logic [31:0]   mmio_rd_q, mmio_rdata;
    logic          rd_mmio_q, rd_valid_q;
    logic [31:0]   cyc_q;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          full, empty, push, pop;

    uart_state_e   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          busy;

    logic [AW-1:0] ram_idx;
    logic          rd_acc, wr_ram, push_req;
    logic          unused_addr;

    // Upper RAM index bits above DEPTH alias; byte offset bits are don't-care.
    assign ram_idx     = addr[AW+1:2];
    assign unused_addr = ^{addr[1:0], addr[14:2]};
    // A simultaneous write wins; the read is dropped entirely.
    assign rd_acc   = ren & ~wen;
    assign wr_ram   = wen & ~addr[15];
    assign push_req = wen & addr[15] & (addr[3:2] == 2'd0) & wmask[3];

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign pop   = (state_q == S_IDLE) & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push  = push_req & (~full | pop);
    assign busy  = (state_q != S_IDLE);

    // RAM: byte-lane writes and registered read, no reset so it maps to block RAM.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_ram && wmask[3-k]) mem[ram_idx][8*k +: 8] <= wdata[8*k +: 8];
        end
        if (rd_acc && !addr[15]) ram_rd_q <= mem[ram_idx];
    end

    // MMIO read mux, sampled at the same edge as the RAM read.
    always_comb begin
        mmio_rdata = 32'd0;
        case (addr[3:2])
            2'd1:    mmio_rdata = {29'd0, busy, empty, full};
            2'd2:    mmio_rdata = cyc_q;
            default: mmio_rdata = 32'd0;
        endcase
    end

    // Read response registers; the MMIO path is selected out of reset so rdata reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_mmio_q  <= 1'b1;
            mmio_rd_q  <= 32'd0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_mmio_q <= addr[15];
                mmio_rd_q <= mmio_rdata;
            end
        end
    end

    assign rdata    = rd_mmio_q ? mmio_rd_q : ram_rd_q;
    assign rd_valid = rd_valid_q;

    // Free-running cycle counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_q <= 32'd0;
        else        cyc_q <= cyc_q + 32'd1;
    end

    // TX FIFO storage.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr_q] <= wdata[7:0];
    end

    // TX FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= (wptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
            if (pop)  rptr_q <= (rptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // UART state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // UART next-state: baud down-counter reloads at every state/bit boundary.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d = S_START;
                    shift_d = fifo_mem[rptr_q];
                    baud_d  = BW'(CLK_DIV - 1);
                end
            end
            S_START: begin
                if (baud_q == '0) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    baud_d  = BW'(CLK_DIV - 1);
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            S_DATA: begin
                if (baud_q == '0) begin
                    baud_d = BW'(CLK_DIV - 1);
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            S_STOP: begin
                if (baud_q == '0) state_d = S_IDLE;
                else              baud_d  = baud_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line level decoded from state so reset forces it high without a clock edge.
    always_comb begin
        uart_tx = 1'b1;
        case (state_q)
            S_START: uart_tx = 1'b0;
            S_DATA:  uart_tx = shift_q[bit_q];
            default: uart_tx = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_mem_bus.sv
// tb_mem_bus: scoreboard bench for mem_bus (CLK_DIV=4, FIFO_DEPTH=4).
module tb_mem_bus;
    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ren = 1'b0, wen = 1'b0;
    logic [15:0] addr = 16'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  wmask = 4'd0;
    logic [31:0] rdata;
    logic        rd_valid, uart_tx;

    mem_bus #(.DEPTH(4096), .INIT_FILE(""), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .ren(ren), .wen(wen), .addr(addr),
        .wdata(wdata), .wmask(wmask), .rdata(rdata), .rd_valid(rd_valid), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] d; int unsigned c; } exp_t;
    exp_t sb[$];
    exp_t e;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc = 0;
    logic [31:0] cyc_model;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected CYCLES value: edges seen since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_model <= 32'd0;
        else        cyc_model <= cyc_model + 32'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Response monitor: every rd_valid pops one expectation, checks data and latency.
    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_rd_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rdata", rdata, e.d);
                chk("rd_latency", cyc, e.c);
            end
        end
    end

    task automatic idle();
        @(posedge clk); #1;
        ren = 1'b0; wen = 1'b0; wmask = 4'd0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [31:0] exp);
        @(posedge clk); #1;
        ren = 1'b1; wen = 1'b0; addr = a; wmask = 4'd0;
        sb.push_back('{d: exp, c: cyc + 1});
    endtask

    task automatic rd_cycles();
        @(posedge clk); #1;
        ren = 1'b1; wen = 1'b0; addr = 16'h8008; wmask = 4'd0;
        sb.push_back('{d: cyc_model, c: cyc + 1});
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
        @(posedge clk); #1;
        ren = 1'b0; wen = 1'b1; addr = a; wdata = d; wmask = m;
    endtask

    task automatic rw(input logic [15:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        ren = 1'b1; wen = 1'b1; addr = a; wdata = d; wmask = 4'hF;
    endtask

    // Serial receiver: exact-length start bit, 8 data bits, stop bit, all glitch-free.
    task automatic rx_byte(output logic [7:0] b, output logic clean, output int gap);
        int n;
        b = 8'd0; clean = 1'b1; n = 0;
        @(negedge clk);
        while (uart_tx !== 1'b0 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        gap = n;
        if (n >= 2000) begin
            clean = 1'b0;
            return;
        end
        for (int i = 1; i < CLK_DIV; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b0) clean = 1'b0;
        end
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < CLK_DIV; i++) begin
                @(negedge clk);
                if (i == 0) b[k] = uart_tx;
                else if (uart_tx !== b[k]) clean = 1'b0;
            end
        end
        for (int i = 0; i < CLK_DIV; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) clean = 1'b0;
        end
    endtask

    task automatic line_quiet(input int ncyc, input string tag);
        logic hi;
        hi = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) hi = 1'b0;
        end
        chk(tag, {31'd0, hi}, 32'd1);
    endtask

    logic [7:0]  rx_b;
    logic        rx_ok;
    int          rx_gap;
    logic [31:0] c0, c1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        rd(16'h8004, 32'h2);
        // Back-to-back reads of word0/word1
        wr(16'h0000, 32'h0000_0100, 4'hF);
        wr(16'h0004, 32'h0000_1000, 4'hF);
        rd(16'h0000, 32'h0000_0100);
        rd(16'h0004, 32'h0000_1000);
        repeat (3) idle();
        chk("rdata_hold", rdata, 32'h0000_1000);

        // Partial lane writes, wmask=0, aliasing above DEPTH
        wr(16'h0200, 32'hAABB_CCDD, 4'b1111);
        wr(16'h0200, 32'h00EE_0000, 4'b0010);
        rd(16'h0200, 32'hAAEE_CCDD);
        wr(16'h0200, 32'hFFFF_FFFF, 4'b0000);
        rd(16'h0200, 32'hAAEE_CCDD);
        wr(16'h0200, 32'h1100_0000, 4'b0001);
        rd(16'h4200, 32'h11EE_CCDD);
        idle();

        // ren and wen together: write only
        rw(16'h0204, 32'h1234_5678);
        repeat (3) idle();
        chk("rw_rdata_unchanged", rdata, 32'h11EE_CCDD);
        rd(16'h0204, 32'h1234_5678);

        // MMIO decode
        rd(16'h8000, 32'h0);
        rd(16'h800C, 32'h0);
        rd(16'h8006, 32'h2);
        wr(16'h800C, 32'hFFFF_FFFF, 4'hF);
        rd(16'h8004, 32'h2);
        idle();

        // CYCLES sampled 10 cycles apart
        rd_cycles();
        idle();
        c0 = rdata;
        repeat (8) idle();
        rd_cycles();
        idle();
        c1 = rdata;
        chk("cycles_diff", c1 - c0, 32'd10);
        idle();

        // Single frame 0x55
        wr(16'h8000, 32'h0000_0055, 4'b1000);
        idle();
        rx_byte(rx_b, rx_ok, rx_gap);
        chk("uart_0x55_byte", {24'd0, rx_b}, 32'h55);
        chk("uart_0x55_frame", {31'd0, rx_ok}, 32'd1);
        rd(16'h8004, 32'h2);
        idle();

        // FIFO fill: 6 writes, the 6th dropped, 5 frames back to back
        fork
            begin
                for (int i = 0; i < 6; i++) wr(16'h8000, 32'h41 + 32'(i), 4'b1000);
                rd(16'h8004, 32'h5);
                idle();
            end
            begin
                for (int f = 0; f < 5; f++) begin
                    rx_byte(rx_b, rx_ok, rx_gap);
                    chk("fifo_byte", {24'd0, rx_b}, 32'h41 + 32'(f));
                    chk("fifo_frame", {31'd0, rx_ok}, 32'd1);
                    if (f > 0) chk("frame_gap", 32'(rx_gap), 32'd1);
                end
            end
        join
        line_quiet(100, "dropped_byte_not_sent");
        rd(16'h8004, 32'h2);
        idle();

        // Reset in the middle of a data bit
        wr(16'h8000, 32'h0, 4'b1000);
        wr(16'h8000, 32'h0, 4'b1000);
        idle();
        repeat (3 * CLK_DIV) @(negedge clk);
        chk("tx_in_data_low", {31'd0, uart_tx}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("tx_async_reset", {31'd0, uart_tx}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd(16'h8004, 32'h2);
        idle();
        line_quiet(60, "queued_bytes_lost");
        rd_cycles();
        repeat (3) idle();

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
